// File: rtl/disp_scan.sv
// Multiplexed N-digit 7-segment display scanner.
// Each digit slot lasts REFRESH_DIV clocks; the first clock of every slot is blanked
// so the previous digit's segments never ghost onto the next one.
// Optional per-digit blinking is enabled by defining DISP_SCAN_BLINK_EN.
module disp_scan #(
    parameter int unsigned DIGITS       = 8,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_we,
    input  logic [$clog2(DIGITS)-1:0] i_waddr,
    input  logic [7:0]                i_wdata,
    input  logic                      i_raw,
    input  logic                      i_en,
`ifdef DISP_SCAN_BLINK_EN
    input  logic [DIGITS-1:0]         i_blink,
`endif
    output logic [DIGITS-1:0]         o_ctl,
    output logic [7:0]                o_disp
);

    localparam int unsigned IdxW = $clog2(DIGITS);
    localparam int unsigned CntW = $clog2(REFRESH_DIV);

    if (DIGITS < 2 || DIGITS > 16 || REFRESH_DIV < 2 || BLINK_FRAMES < 1) begin : g_bad_param
        $error("disp_scan: parameter out of range");
    end

    typedef struct packed {
        logic       raw;
        logic [7:0] data;
    } entry_t;

    entry_t            store_q [DIGITS];
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [DIGITS-1:0] ctl_q, ctl_d;
    logic [7:0]        disp_q, disp_d;
    logic              cnt_wrap, idx_wrap;

    // Active-low segment pattern for one stored entry.
    function automatic logic [7:0] seg(input entry_t e);
        logic [6:0] hex;
        logic [7:0] res;
        case (e.data[3:0])
            4'h0: hex = 7'h40;
            4'h1: hex = 7'h79;
            4'h2: hex = 7'h24;
            4'h3: hex = 7'h30;
            4'h4: hex = 7'h19;
            4'h5: hex = 7'h12;
            4'h6: hex = 7'h02;
            4'h7: hex = 7'h78;
            4'h8: hex = 7'h00;
            4'h9: hex = 7'h10;
            4'hA: hex = 7'h08;
            4'hB: hex = 7'h03;
            4'hC: hex = 7'h46;
            4'hD: hex = 7'h21;
            4'hE: hex = 7'h06;
            default: hex = 7'h0E;
        endcase
        if (e.raw) res = ~e.data;
        else       res = {~e.data[7], hex};
        return res;
    endfunction

    // Slot counter and round-robin digit index.
    always_comb begin
        cnt_wrap = (cnt_q == CntW'(REFRESH_DIV - 1));
        idx_wrap = (idx_q == IdxW'(DIGITS - 1));
        cnt_d    = cnt_wrap ? '0 : cnt_q + CntW'(1);
        idx_d    = idx_q;
        if (cnt_wrap) idx_d = idx_wrap ? '0 : idx_q + IdxW'(1);
    end

`ifdef DISP_SCAN_BLINK_EN
    localparam int unsigned FrmW = $clog2(BLINK_FRAMES + 1);

    logic [FrmW-1:0] frame_q, frame_d;
    logic            phase_q, phase_d;

    // Frame counter: phase flips after BLINK_FRAMES complete scan frames.
    always_comb begin
        frame_d = frame_q;
        phase_d = phase_q;
        if (cnt_wrap && idx_wrap) begin
            if (frame_q == FrmW'(BLINK_FRAMES - 1)) begin
                frame_d = '0;
                phase_d = ~phase_q;
            end else begin
                frame_d = frame_q + FrmW'(1);
            end
        end
    end

    // Blink state registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            frame_q <= '0;
            phase_q <= 1'b0;
        end else begin
            frame_q <= frame_d;
            phase_q <= phase_d;
        end
    end
`endif

    // Output next-state: blank slot on disable or first cycle of each slot.
    always_comb begin
        ctl_d  = '1;
        disp_d = 8'hFF;
        if (i_en && (cnt_q != '0)) begin
            ctl_d[idx_q] = 1'b0;
            disp_d       = seg(store_q[idx_q]);
`ifdef DISP_SCAN_BLINK_EN
            if (phase_q && i_blink[idx_q]) disp_d = 8'hFF;
`endif
        end
    end

    // Counters and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            ctl_q  <= '1;
            disp_q <= 8'hFF;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            ctl_q  <= ctl_d;
            disp_q <= disp_d;
        end
    end

    // Digit store; reset value {raw=1, data=0} decodes to all segments off.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                store_q[i] <= '{raw: 1'b1, data: 8'h00};
            end
        end else if (i_we && (32'(i_waddr) < DIGITS)) begin
            store_q[i_waddr] <= '{raw: i_raw, data: i_wdata};
        end
    end

    assign o_ctl  = ctl_q;
    assign o_disp = disp_q;

endmodule

// File: tb/tb_disp_scan.sv
// Directed self-checking bench for disp_scan (DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2),
// plus a DIGITS=3 instance for out-of-range write addresses.
module tb_disp_scan;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       we = 1'b0;
    logic       we3 = 1'b0;
    logic [1:0] waddr = '0;
    logic [7:0] wdata = '0;
    logic       raw = 1'b0;
    logic       en = 1'b1;
    logic [3:0] blink = '0;
    logic [2:0] blink3 = '0;
    logic [3:0] o_ctl;
    logic [7:0] o_disp;
    logic [2:0] o_ctl3;
    logic [7:0] o_disp3;

    int n_chk = 0;
    int n_fail = 0;

    // Expected segment pattern per digit, set by hand alongside each write.
    logic [7:0] exp_seg [4];

    // Bench-side scan position (post-edge cnt/idx) and blink phase tracking.
    logic [3:0] pos;
    int         frames;
    logic       ph_prev;

    always #5 clk = ~clk;

    disp_scan #(.DIGITS(4), .REFRESH_DIV(4), .BLINK_FRAMES(2)) u_dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_we    (we),
        .i_waddr (waddr),
        .i_wdata (wdata),
        .i_raw   (raw),
        .i_en    (en),
`ifdef DISP_SCAN_BLINK_EN
        .i_blink (blink),
`endif
        .o_ctl   (o_ctl),
        .o_disp  (o_disp)
    );

    disp_scan #(.DIGITS(3), .REFRESH_DIV(2), .BLINK_FRAMES(2)) u_dut3 (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_we    (we3),
        .i_waddr (waddr),
        .i_wdata (wdata),
        .i_raw   (raw),
        .i_en    (en),
`ifdef DISP_SCAN_BLINK_EN
        .i_blink (blink3),
`endif
        .o_ctl   (o_ctl3),
        .o_disp  (o_disp3)
    );

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pos     <= '0;
            frames  <= 0;
            ph_prev <= 1'b0;
        end else begin
            pos     <= pos + 4'd1;
            if (pos == 4'd15) frames <= frames + 1;
            ph_prev <= frames[1];
        end
    end

    function automatic logic [3:0] m_ctl(input logic [3:0] p);
        if (p[1:0] == 2'd0) return 4'hF;
        return ~(4'b0001 << p[3:2]);
    endfunction

    function automatic logic [7:0] m_disp(input logic [3:0] p);
        if (p[1:0] == 2'd0) return 8'hFF;
`ifdef DISP_SCAN_BLINK_EN
        if (ph_prev && blink[p[3:2]]) return 8'hFF;
`endif
        return exp_seg[p[3:2]];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [1:0] a, input logic [7:0] d, input logic r);
        waddr = a;
        wdata = d;
        raw   = r;
        we    = 1'b1;
        tick();
        we    = 1'b0;
    endtask

    // Advance until the outputs reflect pre-edge scan position p.
    task automatic goto(input logic [3:0] p);
        int n = 0;
        while ((pos - 4'd1) != p && n < 20) begin
            tick();
            n++;
        end
        if ((pos - 4'd1) != p) begin
            n_chk++;
            n_fail++;
            $display("FAIL goto: position %0d required %0d", pos - 4'd1, p);
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        n_chk++;
        if (o_ctl !== 4'hF || o_disp !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset_async: ctl=%h disp=%h required F/FF", o_ctl, o_disp);
        end
        repeat (2) tick();
        n_chk++;
        if (o_ctl !== 4'hF || o_disp !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset_hold: ctl=%h disp=%h required F/FF", o_ctl, o_disp);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) exp_seg[i] = 8'hFF;
    endtask

    task automatic test_raw_scan();
        write_entry(2'd0, 8'h01, 1'b1);
        write_entry(2'd1, 8'h02, 1'b1);
        write_entry(2'd2, 8'h04, 1'b1);
        write_entry(2'd3, 8'h08, 1'b1);
        exp_seg[0] = 8'hFE;
        exp_seg[1] = 8'hFD;
        exp_seg[2] = 8'hFB;
        exp_seg[3] = 8'hF7;
        goto(4'd0);
        for (int i = 0; i < 32; i++) begin
            n_chk++;
            if (o_ctl !== m_ctl(pos - 4'd1) || o_disp !== m_disp(pos - 4'd1)) begin
                n_fail++;
                $display("FAIL raw_scan[%0d]: ctl=%h disp=%h required %h/%h", i, o_ctl,
                         o_disp, m_ctl(pos - 4'd1), m_disp(pos - 4'd1));
            end
            tick();
        end
    endtask

    task automatic test_hex();
        write_entry(2'd0, 8'h00, 1'b0);
        write_entry(2'd1, 8'h0A, 1'b0);
        write_entry(2'd2, 8'h8F, 1'b0);
        exp_seg[0] = 8'hC0;
        exp_seg[1] = 8'h88;
        exp_seg[2] = 8'h0E;
        goto(4'd1);
        n_chk++;
        if (o_ctl !== 4'b1110 || o_disp !== 8'hC0) begin
            n_fail++;
            $display("FAIL hex_0: ctl=%h disp=%h required E/C0", o_ctl, o_disp);
        end
        goto(4'd5);
        n_chk++;
        if (o_ctl !== 4'b1101 || o_disp !== 8'h88) begin
            n_fail++;
            $display("FAIL hex_A: ctl=%h disp=%h required D/88", o_ctl, o_disp);
        end
        goto(4'd9);
        n_chk++;
        if (o_ctl !== 4'b1011 || o_disp !== 8'h0E) begin
            n_fail++;
            $display("FAIL hex_F_dp: ctl=%h disp=%h required B/0E", o_ctl, o_disp);
        end
    endtask

    task automatic test_collision();
        goto(4'd13);
        n_chk++;
        if (o_disp !== 8'hF7) begin
            n_fail++;
            $display("FAIL coll_before: disp=%h required F7", o_disp);
        end
        waddr = 2'd3;
        wdata = 8'h80;
        raw   = 1'b1;
        we    = 1'b1;
        tick();
        we    = 1'b0;
        n_chk++;
        if (o_ctl !== 4'b0111 || o_disp !== 8'hF7) begin
            n_fail++;
            $display("FAIL coll_edge: ctl=%h disp=%h required 7/F7", o_ctl, o_disp);
        end
        tick();
        exp_seg[3] = 8'h7F;
        n_chk++;
        if (o_ctl !== 4'b0111 || o_disp !== 8'h7F) begin
            n_fail++;
            $display("FAIL coll_after: ctl=%h disp=%h required 7/7F", o_ctl, o_disp);
        end
        goto(4'd1);
        n_chk++;
        if (o_disp !== 8'hC0) begin
            n_fail++;
            $display("FAIL coll_d0: disp=%h required C0", o_disp);
        end
        goto(4'd5);
        n_chk++;
        if (o_disp !== 8'h88) begin
            n_fail++;
            $display("FAIL coll_d1: disp=%h required 88", o_disp);
        end
        goto(4'd9);
        n_chk++;
        if (o_disp !== 8'h0E) begin
            n_fail++;
            $display("FAIL coll_d2: disp=%h required 0E", o_disp);
        end
    endtask

    task automatic test_out_of_range();
        int lit = 0;
        waddr = 2'd3;
        wdata = 8'hFF;
        raw   = 1'b1;
        we3   = 1'b1;
        tick();
        we3   = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_chk++;
            if (o_disp3 !== 8'hFF) begin
                n_fail++;
                $display("FAIL oor_ignored[%0d]: disp=%h required FF", i, o_disp3);
            end
        end
        waddr = 2'd2;
        wdata = 8'h01;
        we3   = 1'b1;
        tick();
        we3   = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            tick();
            if (o_disp3 === 8'hFE && o_ctl3 === 3'b011) lit++;
        end
        n_chk++;
        if (lit != 1) begin
            n_fail++;
            $display("FAIL oor_valid_write: lit cycles=%0d required 1", lit);
        end
    endtask

    task automatic test_enable();
        goto(4'd6);
        n_chk++;
        if (o_disp !== 8'h88) begin
            n_fail++;
            $display("FAIL en_before: disp=%h required 88", o_disp);
        end
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_chk++;
            if (o_ctl !== 4'hF || o_disp !== 8'hFF) begin
                n_fail++;
                $display("FAIL en_off[%0d]: ctl=%h disp=%h required F/FF", i, o_ctl, o_disp);
            end
        end
        en = 1'b1;
        tick();
        n_chk++;
        if (o_ctl !== 4'b1011 || o_disp !== 8'h0E) begin
            n_fail++;
            $display("FAIL en_resume: ctl=%h disp=%h required B/0E", o_ctl, o_disp);
        end
    endtask

    task automatic test_reset_mid();
        goto(4'd10);
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if (o_ctl !== 4'hF || o_disp !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset_mid: ctl=%h disp=%h required F/FF", o_ctl, o_disp);
        end
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) exp_seg[i] = 8'hFF;
        for (int i = 0; i < 16; i++) begin
            tick();
            n_chk++;
            if (o_ctl !== m_ctl(pos - 4'd1) || o_disp !== 8'hFF) begin
                n_fail++;
                $display("FAIL reset_blank[%0d]: ctl=%h disp=%h required %h/FF", i, o_ctl,
                         o_disp, m_ctl(pos - 4'd1));
            end
        end
    endtask

`ifdef DISP_SCAN_BLINK_EN
    task automatic test_blink();
        int on = 0;
        int off = 0;
        write_entry(2'd0, 8'h01, 1'b1);
        write_entry(2'd1, 8'h02, 1'b1);
        write_entry(2'd2, 8'h04, 1'b1);
        write_entry(2'd3, 8'h08, 1'b1);
        exp_seg[0] = 8'hFE;
        exp_seg[1] = 8'hFD;
        exp_seg[2] = 8'hFB;
        exp_seg[3] = 8'hF7;
        blink = 4'b0010;
        for (int i = 0; i < 80; i++) begin
            tick();
            n_chk++;
            if (o_ctl !== m_ctl(pos - 4'd1) || o_disp !== m_disp(pos - 4'd1)) begin
                n_fail++;
                $display("FAIL blink[%0d]: ctl=%h disp=%h required %h/%h", i, o_ctl, o_disp,
                         m_ctl(pos - 4'd1), m_disp(pos - 4'd1));
            end
            if (o_ctl === 4'b1101 && o_disp === 8'hFD) on++;
            if (o_ctl === 4'b1101 && o_disp === 8'hFF) off++;
        end
        n_chk++;
        if (on == 0 || off == 0) begin
            n_fail++;
            $display("FAIL blink_both_phases: lit=%0d blanked=%0d required both nonzero", on, off);
        end
        blink = 4'b0000;
    endtask
`endif

    initial begin
        test_reset();
        test_raw_scan();
        test_hex();
        test_collision();
        test_out_of_range();
        test_enable();
        test_reset_mid();
`ifdef DISP_SCAN_BLINK_EN
        test_blink();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/disp_scan.md
Name: disp_scan

Overview:
- Parametrised N-digit multiplexed 7-segment display controller; successor to the fixed 8-bit o_ctl/o_disp drive of the syscall unit.
- Holds one 8-bit entry per digit, written by the processor's syscall path.
- Scans the digits round-robin with a programmable refresh divider.
- Per-digit hex-decode or raw-segment mode, global enable, inter-digit blanking cycle for anti-ghosting.

Parameters:
- DIGITS, 8, number of digits; 2..16.
- REFRESH_DIV, 50000, clocks per digit slot; >= 2.
- BLINK_FRAMES, 64, full scan frames per blink phase; used only with DISP_SCAN_BLINK_EN.

Ports:
- i_clk  in  1  clock; all state changes on rising edge.
- i_rst  in  1  reset; asynchronous, active-high.
- i_we  in  1  write strobe for the digit store.
- i_waddr  in  $clog2(DIGITS)  digit index to write.
- i_wdata  in  8  digit data.
- i_raw  in  1  write mode. 1 = raw segments, i_wdata[7:0] = {dp,g,f,e,d,c,b,a}, active-high. 0 = hex mode, i_wdata[3:0] = nibble, i_wdata[7] = dp.
- i_en  in  1  display enable.
- o_ctl  out  DIGITS  digit select, one-hot, active-low.
- o_disp  out  8  segments {dp,g..a}, active-low.

Behaviour:
- Digit store
  - DIGITS entries of {raw bit, 8 data bits}.
  - Write on rising edge when i_we=1; i_waddr >= DIGITS is ignored.
- Counters
  - cnt counts 0..REFRESH_DIV-1.
  - At REFRESH_DIV-1, cnt wraps to 0 and idx advances; idx wraps from DIGITS-1 to 0.
- Output registers
  - o_ctl/o_disp are registers loaded every cycle from pre-edge idx, cnt and store, giving a 1-cycle lag.
  - Blank slot: if i_en=0 or cnt==0, load o_ctl = all ones and o_disp = 8'hFF.
  - Otherwise load o_ctl = ~(1<<idx) and o_disp = seg(store[idx]).
- seg() decode
  - Raw entry: ~data.
  - Hex entry: {~dp, table[nibble]}. Table in gfedcba, active-low: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
  - With dp=0 this gives, e.g., 0 -> 8'hC0 and F -> 8'h8E.
- Write/display collision: a write to the digit being displayed shows on o_disp on the cycle after the next edge, with no tearing.
- i_en=0 blanks outputs only; cnt, idx and writes continue.
- Reset
  - idx=0, cnt=0, all entries {raw=1, data=0}, which display as blank.
  - o_ctl = all ones, o_disp = 8'hFF.
  - Asserting reset mid-scan forces these values immediately, without waiting for a clock edge.
- Frame: DIGITS*REFRESH_DIV clocks. Each digit is lit REFRESH_DIV-1 cycles per frame.

Optional Feature:
- Macro: DISP_SCAN_BLINK_EN.
- Defined:
  - Adds port i_blink (in, DIGITS bits), the per-digit blink mask.
  - A frame counter toggles a phase bit every BLINK_FRAMES frames, counted at idx wrap DIGITS-1 -> 0 together with cnt wrap.
  - While phase=1, masked digits output o_disp = 8'hFF; o_ctl still selects them.
  - Reset clears phase and the frame counter.
- Undefined: i_blink port absent, no blinking, no frame counter.

Test Plan (DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2):
- Reset, then write raw entries 8'h01, 8'h02, 8'h04, 8'h08 to digits 0..3 with i_en=1 -> per frame:
  - o_ctl blanks for 1 cycle, then holds 4'b1110 for 3 cycles with o_disp = FE.
  - Then 1101 with FD, 1011 with FB, 0111 with F7.
  - Frame repeats every 16 cycles.
- Hex writes: 0x0 to digit 0, 0xA to digit 1, 0x8F (dp set) to digit 2 -> o_disp = C0, 88, 0E respectively in those slots.
- Write to digit 3 while digit 3 is lit -> o_disp changes the cycle after the next edge; no other digit is affected. Write with i_waddr out of range on a non-power-of-2 build -> store unchanged.
- i_en=0 mid-frame -> o_ctl = 4'hF and o_disp = FF after 1 cycle. Re-enable -> scan resumes at the free-running idx, with no restart to digit 0.
- Assert i_rst mid-slot -> outputs go to F/FF at once without a clock edge. After release, digits stay blank until rewritten.
- Blink build, i_blink = 4'b0010 -> digit 1 segments alternate between lit and FF every 2 frames (32 cycles). Other digits stay steady.
